cpu_fetch_stage: RTL and testbench

Instruction fetch stage feeding the decode stage. Holds the PC, issues one instruction-cache request at a time, and captures the returned 32-bit word plus the I-TLB miss flag into the fetch/decode pipeline register. Also absorbs decode back-pressure with a one-entry skid buffer and handles branch/exception redirects, including discarding in-flight responses.

---
 rtl/cpu_fetch_stage.sv | 169 ++++++++++++++++
 tb/tb_cpu_fetch_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding I-cache request, fetch/decode register with skid.
// Define CPU_FETCH_PERF_EN to add the perf_fetch_count / perf_stall_cycles counters.
`ifndef VIRTUAL_ADDR_WIDTH
`define VIRTUAL_ADDR_WIDTH 32
`endif

module cpu_fetch_stage #(
    parameter int                ADDR_W  = `VIRTUAL_ADDR_WIDTH,
    parameter logic [ADDR_W-1:0] BOOT_PC = ADDR_W'('h1000)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              icache_req_valid,
    input  logic              icache_req_ready,
    output logic [ADDR_W-1:0] icache_req_addr,
    input  logic              icache_rsp_valid,
    input  logic [31:0]       icache_rsp_data,
    input  logic              icache_rsp_tlb_miss,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] dec_next_PC,
    output logic              dec_valid_instr,
    output logic [31:0]       dec_instr,
    output logic              dec_nop,
    output logic              dec_tlb_miss
`ifdef CPU_FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_count,
    output logic [31:0]       perf_stall_cycles
`endif
);

    typedef enum logic [2:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN, S_HALT} state_t;

    typedef struct packed {
        logic              vld;
        logic [31:0]       instr;
        logic [ADDR_W-1:0] npc;
        logic              tlb;
    } dec_t;

    typedef struct packed {
        logic        vld;
        logic [31:0] instr;
        logic        tlb;
    } skid_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt, pc_inc;
    dec_t              dec_q, dec_nxt;
    skid_t             skid_q, skid_nxt;
    logic              cap, cap_tlb, deliver;
    logic [31:0]       cap_word;

    assign pc_inc           = pc + ADDR_W'(4);
    assign icache_req_valid = rst_n && (state == S_REQ);
    assign icache_req_addr  = pc;
    assign dec_next_PC      = dec_q.npc;
    assign dec_valid_instr  = dec_q.vld;
    assign dec_instr        = dec_q.instr;
    assign dec_nop          = !dec_q.vld;
    assign dec_tlb_miss     = dec_q.tlb;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        dec_nxt   = dec_q;
        skid_nxt  = skid_q;
        cap       = 1'b0;
        cap_word  = '0;
        cap_tlb   = 1'b0;
        deliver   = 1'b0;

        // Unstalled decode consumes the register; next_PC is left as-is on bubbles.
        if (!stall) begin
            dec_nxt.vld   = 1'b0;
            dec_nxt.instr = '0;
            dec_nxt.tlb   = 1'b0;
        end

        case (state)
            S_REQ: if (icache_req_ready) state_nxt = S_WAIT;
            S_WAIT: begin
                if (icache_rsp_valid) begin
                    if (!dec_q.vld || !stall) begin
                        cap      = 1'b1;
                        cap_word = icache_rsp_data;
                        cap_tlb  = icache_rsp_tlb_miss;
                    end else begin
                        skid_nxt.vld   = 1'b1;
                        skid_nxt.instr = icache_rsp_data;
                        skid_nxt.tlb   = icache_rsp_tlb_miss;
                        state_nxt      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!stall && skid_q.vld) begin
                    cap          = 1'b1;
                    cap_word     = skid_q.instr;
                    cap_tlb      = skid_q.tlb;
                    skid_nxt.vld = 1'b0;
                end
            end
            S_DRAIN: if (icache_rsp_valid) state_nxt = S_REQ;
            default: ;
        endcase

        if (cap) begin
            if (cap_tlb) begin
                dec_nxt.vld   = 1'b0;
                dec_nxt.instr = '0;
                dec_nxt.tlb   = 1'b1;
                state_nxt     = S_HALT;
            end else begin
                dec_nxt.vld   = 1'b1;
                dec_nxt.instr = cap_word;
                dec_nxt.npc   = pc_inc;
                dec_nxt.tlb   = 1'b0;
                pc_nxt        = pc_inc;
                state_nxt     = S_REQ;
                deliver       = 1'b1;
            end
        end

        // Redirect overrides everything; a request still in flight must be drained.
        if (redirect_valid) begin
            dec_nxt.vld   = 1'b0;
            dec_nxt.instr = '0;
            dec_nxt.tlb   = 1'b0;
            skid_nxt.vld  = 1'b0;
            pc_nxt        = redirect_pc & ~ADDR_W'(3);
            deliver       = 1'b0;
            if ((state == S_REQ && icache_req_ready) ||
                ((state == S_WAIT || state == S_DRAIN) && !icache_rsp_valid))
                state_nxt = S_DRAIN;
            else
                state_nxt = S_REQ;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_REQ;
            pc     <= BOOT_PC;
            dec_q  <= '0;
            skid_q <= '0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            dec_q  <= dec_nxt;
            skid_q <= skid_nxt;
        end
    end

`ifdef CPU_FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_count  <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (deliver) perf_fetch_count <= perf_fetch_count + 32'd1;
            if (state == S_WAIT || state == S_HOLD) perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_fetch_stage.sv
// Bench for cpu_fetch_stage: I-cache model, directed scenarios, and a per-cycle instruction-stream checker.
module tb_cpu_fetch_stage;

    logic        clk, rst_n;
    logic        icache_req_valid, icache_req_ready;
    logic [31:0] icache_req_addr;
    logic        icache_rsp_valid, icache_rsp_tlb_miss;
    logic [31:0] icache_rsp_data;
    logic        stall, redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] dec_next_PC, dec_instr;
    logic        dec_valid_instr, dec_nop, dec_tlb_miss;
`ifdef CPU_FETCH_PERF_EN
    logic [31:0] perf_fetch_count, perf_stall_cycles;
`endif

    cpu_fetch_stage dut (
        .clk(clk), .rst_n(rst_n),
        .icache_req_valid(icache_req_valid), .icache_req_ready(icache_req_ready),
        .icache_req_addr(icache_req_addr),
        .icache_rsp_valid(icache_rsp_valid), .icache_rsp_data(icache_rsp_data),
        .icache_rsp_tlb_miss(icache_rsp_tlb_miss),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_next_PC(dec_next_PC), .dec_valid_instr(dec_valid_instr), .dec_instr(dec_instr),
        .dec_nop(dec_nop), .dec_tlb_miss(dec_tlb_miss)
`ifdef CPU_FETCH_PERF_EN
        , .perf_fetch_count(perf_fetch_count), .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    int tests = 0, fails = 0;
    int lat = 1;
    logic [31:0] tlb_addr = 32'hFFFF_FFFF;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h0022_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // I-cache: one outstanding request, response after 'lat' cycles.
    logic        acc_s;
    logic [31:0] acc_a;
    initial begin
        acc_s = 0; acc_a = 0;
        forever begin
            @(negedge clk);
            acc_s = icache_req_valid && icache_req_ready;
            acc_a = icache_req_addr;
        end
    end

    initial begin
        logic        a, pend;
        logic [31:0] aa, paddr;
        int          pcnt;
        pend = 0; paddr = 0; pcnt = 0;
        icache_rsp_valid = 0; icache_rsp_data = 0; icache_rsp_tlb_miss = 0;
        forever begin
            @(posedge clk);
            a = acc_s; aa = acc_a;
            #1;
            icache_rsp_valid = 0; icache_rsp_data = 0; icache_rsp_tlb_miss = 0;
            if (!rst_n) pend = 0;
            else begin
                if (a) begin pend = 1; paddr = aa; pcnt = lat - 1; end
                if (pend) begin
                    if (pcnt == 0) begin
                        icache_rsp_valid    = 1;
                        icache_rsp_data     = mem(paddr);
                        icache_rsp_tlb_miss = (paddr == tlb_addr);
                        pend = 0;
                    end else pcnt--;
                end
            end
        end
    end

    // Stream model: fetch address advances by 4 on each instruction delivered to decode,
    // jumps on redirect, and stops after a TLB fault until redirected.
    initial begin
        logic [31:0] m_pc, p_i, p_np;
        logic        m_halt, pv, ps, pr, pt;
        int          deliv;
        m_pc = 32'h1000; m_halt = 0; pv = 0; ps = 0; pr = 0; pt = 0; p_i = 0; p_np = 0; deliv = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_pc = 32'h1000; m_halt = 0; pv = 0; ps = 0; pr = 0; pt = 0; deliv = 0;
            end else begin
                chk("nop_vs_valid", dec_nop, !dec_valid_instr);
                if (pv && ps && !pr) begin
                    chk("hold_valid", dec_valid_instr, 1);
                    chk("hold_instr", dec_instr, p_i);
                    chk("hold_npc", dec_next_PC, p_np);
                end else if (dec_valid_instr) begin
                    chk("deliv_instr", dec_instr, mem(m_pc));
                    chk("deliv_npc", dec_next_PC, m_pc + 32'd4);
                    m_pc += 32'd4;
                    deliv++;
                end else begin
                    chk("bubble_instr", dec_instr, 0);
                end
                if (dec_tlb_miss && !(pt && ps)) m_halt = 1;
                if (m_halt) chk("halt_noreq", icache_req_valid, 0);
                else if (icache_req_valid) chk("req_addr", icache_req_addr, m_pc);
`ifdef CPU_FETCH_PERF_EN
                chk("perf_fetch", perf_fetch_count, deliv);
`endif
                if (redirect_valid) begin
                    m_pc = redirect_pc & ~32'd3;
                    m_halt = 0;
                end
                pv = dec_valid_instr; ps = stall; pr = redirect_valid; pt = dec_tlb_miss;
                p_i = dec_instr; p_np = dec_next_PC;
            end
        end
    end

    initial begin
        rst_n = 0; icache_req_ready = 0; stall = 0; redirect_valid = 0; redirect_pc = 0;
        repeat (3) step();
        chk("rst_req_valid", icache_req_valid, 0);
        chk("rst_valid", dec_valid_instr, 0);
        chk("rst_nop", dec_nop, 1);
        chk("rst_instr", dec_instr, 0);
        chk("rst_npc", dec_next_PC, 0);
        chk("rst_tlb", dec_tlb_miss, 0);
        rst_n = 1; icache_req_ready = 1;
        #1;
        // Boot fetch
        chk("boot_req", icache_req_valid, 1);
        chk("boot_addr", icache_req_addr, 32'h1000);
        step();
        chk("wait_noreq", icache_req_valid, 0);
        step();
        chk("t1_valid", dec_valid_instr, 1);
        chk("t1_instr", dec_instr, 32'h0022_1000);
        chk("t1_npc", dec_next_PC, 32'h1004);
        chk("t1_next_addr", icache_req_addr, 32'h1004);
        // Stall with a response in flight -> skid
        stall = 1;
        step();
        chk("t2_held_instr", dec_instr, 32'h0022_1000);
        step();
        chk("t2_hold_noreq", icache_req_valid, 0);
        chk("t2_hold_instr", dec_instr, 32'h0022_1000);
        stall = 0;
        step();
        chk("t2_skid_instr", dec_instr, 32'h0022_1004);
        chk("t2_skid_npc", dec_next_PC, 32'h1008);
        chk("t2_req_addr", icache_req_addr, 32'h1008);
        // Redirect in WAIT with a late response
        lat = 2;
        step();
        redirect_valid = 1; redirect_pc = 32'h2003;
        step();
        redirect_valid = 0;
        chk("t3_bubble", dec_valid_instr, 0);
        chk("t3_drain_noreq", icache_req_valid, 0);
        step();
        chk("t3_req_valid", icache_req_valid, 1);
        chk("t3_req_addr", icache_req_addr, 32'h2000);
        chk("t3_discarded", dec_valid_instr, 0);
        lat = 1;
        step(); step();
        chk("t3_instr", dec_instr, 32'h0022_2000);
        // TLB miss on 0x2004
        tlb_addr = 32'h2004;
        step(); step();
        chk("t4_tlb", dec_tlb_miss, 1);
        chk("t4_nop", dec_nop, 1);
        chk("t4_instr", dec_instr, 0);
        chk("t4_noreq", icache_req_valid, 0);
        step(); step();
        chk("t4_halt_noreq", icache_req_valid, 0);
        chk("t4_tlb_cleared", dec_tlb_miss, 0);
        tlb_addr = 32'hFFFF_FFFF;
        redirect_valid = 1; redirect_pc = 32'h3000;
        step();
        chk("t4_restart_addr", icache_req_addr, 32'h3000);
        chk("t4_restart_req", icache_req_valid, 1);
        // Redirect in REQ while accepted -> drain, then wrap at top of address space
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 0;
        chk("t5_drain_noreq", icache_req_valid, 0);
        step();
        chk("t5_req_addr", icache_req_addr, 32'hFFFF_FFFC);
        step(); step();
        chk("t5_instr", dec_instr, 32'hFFDD_FFFC);
        chk("t5_npc_wrap", dec_next_PC, 32'h0);
        chk("t5_req_wrap", icache_req_addr, 32'h0);
        // Mixed traffic, checked by the stream model
        for (int i = 0; i < 400; i++) begin
            icache_req_ready = ($urandom_range(0, 3) != 0);
            stall            = ($urandom_range(0, 3) == 0);
            lat              = $urandom_range(1, 3);
            redirect_valid   = ($urandom_range(0, 29) == 0);
            redirect_pc      = 32'h4000 + ($urandom_range(0, 63) << 2) + $urandom_range(0, 3);
            step();
        end
        redirect_valid = 0; stall = 0; icache_req_ready = 1;
        step();
        // Reset mid-stream
        rst_n = 0;
        #1;
        chk("mid_rst_req", icache_req_valid, 0);
        chk("mid_rst_valid", dec_valid_instr, 0);
        chk("mid_rst_instr", dec_instr, 0);
        chk("mid_rst_npc", dec_next_PC, 0);
        step(); step();
        rst_n = 1;
        #1;
        chk("mid_rst_restart", icache_req_addr, 32'h1000);
        repeat (6) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
